// File: rtl/vga_timing_xga.sv
// Free-running raster timing generator (XGA 1024x768@60 by default).
// Counters and every decoded output are co-registered from the next counter values.
module vga_timing_xga #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hblnk,
  output logic        vblnk,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
      $error("vga_timing_xga: H_TOTAL/V_TOTAL do not fit 11-bit counters");
    end
  endgenerate

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic        h_wrap;
  logic [10:0] h_next;
  logic [10:0] v_next;

  always_comb begin
    h_wrap = (hcount == H_LAST);
    h_next = h_wrap ? 11'd0 : hcount + 11'd1;
    v_next = vcount;
    if (h_wrap) begin
      v_next = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
    end
  end

  // Decode from h_next/v_next so each output describes the coordinates it is registered with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hblnk       <= (h_next >= H_ACT);
      vblnk       <= (v_next >= V_ACT);
      hsync       <= ((h_next >= HS_START) && (h_next <= HS_END)) ? HS_POL : ~HS_POL;
      vsync       <= ((v_next >= VS_START) && (v_next <= VS_END)) ? VS_POL : ~VS_POL;
      frame_start <= (h_next == 11'd0) && (v_next == 11'd0);
    end
  end

endmodule

// File: tb/tb_vga_timing_xga.sv
// Bench for vga_timing_xga: default XGA, 640x480 and a tiny raster (active-high syncs)
// instance share one clock/reset so frame-level behaviour can be checked in few cycles.
module tb_vga_timing_xga;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [10:0] x_h, x_v, g_h, g_v, t_h, t_v;
  logic x_hb, x_vb, x_hs, x_vs, x_fs;
  logic g_hb, g_vb, g_hs, g_vs, g_fs;
  logic t_hb, t_vb, t_hs, t_vs, t_fs;

  vga_timing_xga u_xga (
    .clk(clk), .rst(rst), .hcount(x_h), .vcount(x_v), .hblnk(x_hb), .vblnk(x_vb),
    .hsync(x_hs), .vsync(x_vs), .frame_start(x_fs)
  );

  vga_timing_xga #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_vga (
    .clk(clk), .rst(rst), .hcount(g_h), .vcount(g_v), .hblnk(g_hb), .vblnk(g_vb),
    .hsync(g_hs), .vsync(g_vs), .frame_start(g_fs)
  );

  // 16 x 11 raster: frame of 176 cycles, hsync h=10..12, vsync v=7..8, both active-high.
  vga_timing_xga #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_tiny (
    .clk(clk), .rst(rst), .hcount(t_h), .vcount(t_v), .hblnk(t_hb), .vblnk(t_vb),
    .hsync(t_hs), .vsync(t_vs), .frame_start(t_fs)
  );

  typedef struct {
    int inst;
    int cyc;
    int h;
    int v;
    bit hb, vb, hs, vs, fs;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int failed = 0;

  function automatic vec_t mk(int inst, int cyc, int h, int v, bit hb, bit vb, bit hs, bit vs, bit fs);
    vec_t r;
    r.inst = inst; r.cyc = cyc; r.h = h; r.v = v;
    r.hb = hb; r.vb = vb; r.hs = hs; r.vs = vs; r.fs = fs;
    return r;
  endfunction

  function automatic logic [26:0] pack(int h, int v, bit hb, bit vb, bit hs, bit vs, bit fs);
    return {h[10:0], v[10:0], hb, vb, hs, vs, fs};
  endfunction

  function logic [26:0] sample(int inst);
    case (inst)
      0:       return {x_h, x_v, x_hb, x_vb, x_hs, x_vs, x_fs};
      1:       return {g_h, g_v, g_hb, g_vb, g_hs, g_vs, g_fs};
      default: return {t_h, t_v, t_hb, t_vb, t_hs, t_vs, t_fs};
    endcase
  endfunction

  function automatic string fmt(logic [26:0] p);
    return $sformatf("h=%0d v=%0d hb=%0b vb=%0b hs=%0b vs=%0b fs=%0b",
                     p[26:16], p[15:5], p[4], p[3], p[2], p[1], p[0]);
  endfunction

  task automatic check_vec(string name, logic [26:0] got, logic [26:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %s, required %s", name, fmt(got), fmt(exp));
    end else begin
      $display("[TB] %s ok: %s", name, fmt(got));
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end else begin
      $display("[TB] %s ok: %0d", name, got);
    end
  endtask

  task automatic check_reset_state(string tag);
    check_vec({tag, "_xga"},  sample(0), pack(0, 0, 0, 0, 1, 1, 0));
    check_vec({tag, "_vga"},  sample(1), pack(0, 0, 0, 0, 1, 1, 0));
    check_vec({tag, "_tiny"}, sample(2), pack(0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [26:0] s;
    int          cnt;
    int          vs_cnt;
    int          vb_cnt;
    int          bad_edges;
    int          first_fs;
    bit          prev_vs;
    bit          found;

    // XGA line timing
    vecs.push_back(mk(0,    1,    1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1023, 1023, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1024, 1024, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1047, 1047, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1048, 1048, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1183, 1183, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1184, 1184, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1343, 1343, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1344,    0, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1345,    1, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 2687, 1343, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 2688,    0, 2, 0, 0, 1, 1, 0));
    // 640x480 line timing
    vecs.push_back(mk(1,  639, 639, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1,  640, 640, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1,  655, 655, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1,  656, 656, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1,  751, 751, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1,  752, 752, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1,  799, 799, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1,  800,   0, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 1600,   0, 2, 0, 0, 1, 1, 0));
    // tiny raster: sync windows, vblank, frame wrap
    vecs.push_back(mk(2,   9,  9,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(2,  10, 10,  0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(2,  12, 12,  0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(2,  13, 13,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(2,  15, 15,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(2,  16,  0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2,  95, 15,  5, 1, 0, 0, 0, 0));
    vecs.push_back(mk(2,  96,  0,  6, 0, 1, 0, 0, 0));
    vecs.push_back(mk(2, 111, 15,  6, 1, 1, 0, 0, 0));
    vecs.push_back(mk(2, 112,  0,  7, 0, 1, 0, 1, 0));
    vecs.push_back(mk(2, 143, 15,  8, 1, 1, 0, 1, 0));
    vecs.push_back(mk(2, 144,  0,  9, 0, 1, 0, 0, 0));
    vecs.push_back(mk(2, 175, 15, 10, 1, 1, 0, 0, 0));
    vecs.push_back(mk(2, 176,  0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(2, 177,  1,  0, 0, 0, 0, 0, 0));

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_reset_state($sformatf("reset_hold%0d", i));
    end
    @(negedge clk);
    rst = 1'b0;

    // Vector table, indexed by edges since release
    for (int n = 1; n <= 2700; n++) begin
      @(posedge clk); #1;
      foreach (vecs[k]) begin
        if (vecs[k].cyc == n) begin
          check_vec($sformatf("vec%0d_inst%0d_cyc%0d", k, vecs[k].inst, n),
                    sample(vecs[k].inst),
                    pack(vecs[k].h, vecs[k].v, vecs[k].hb, vecs[k].vb,
                         vecs[k].hs, vecs[k].vs, vecs[k].fs));
        end
      end
    end

    // Tiny frame: period, strobe width, vsync/vblank extent, vsync edges at hcount==0 only
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (t_fs) found = 1'b1;
    end
    check_int("tiny_first_fs_seen", int'(found), 1);
    vs_cnt = int'(t_vs);
    vb_cnt = int'(t_vb);
    prev_vs = t_vs;
    bad_edges = 0;
    cnt = 0;
    found = 1'b0;
    for (int i = 1; i <= 400 && !found; i++) begin
      @(posedge clk); #1;
      if (i == 1) check_int("tiny_fs_width", int'(t_fs), 0);
      if (t_fs) begin
        found = 1'b1;
        cnt = i;
      end else begin
        vs_cnt += int'(t_vs);
        vb_cnt += int'(t_vb);
        if (t_vs != prev_vs && t_h != 11'd0) bad_edges++;
        prev_vs = t_vs;
      end
    end
    check_int("tiny_frame_period", cnt, 176);
    check_int("tiny_vsync_cycles", vs_cnt, 32);
    check_int("tiny_vblnk_cycles", vb_cnt, 80);
    check_int("tiny_vsync_edges_off_h0", bad_edges, 0);

    // Mid-line asynchronous reset at XGA hcount==700
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #1;
      if (x_h == 11'd700) found = 1'b1;
    end
    check_int("xga_reach_h700", int'(found), 1);
    #2 rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(posedge clk); #2;
    rst = 1'b0;
    first_fs = 0;
    for (int n = 1; n <= 1344; n++) begin
      @(posedge clk); #1;
      if (n == 1)    check_vec("post_reset_xga_n1",    sample(0), pack(1, 0, 0, 0, 1, 1, 0));
      if (n == 1344) check_vec("post_reset_xga_n1344", sample(0), pack(0, 1, 0, 0, 1, 1, 0));
      if (t_fs && first_fs == 0) first_fs = n;
    end
    check_int("post_reset_tiny_first_fs", first_fs, 176);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vga_timing_xga.md
# vga_timing_xga

Free-running raster timing generator for 1024x768 @ 60 Hz (XGA) on the 65 MHz pixel clock produced by the board clock wizard. It sits at the head of the video pipeline inside the VGA top, upstream of the background and overlay draw stages. It emits registered pixel coordinates, blanking, sync pulses and a frame-start strobe. Every downstream stage consumes these as one coherent bus.

## Interface
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines)
- HS_POL, 1'b0, active level of hsync (0 = active-low)
- VS_POL, 1'b0, active level of vsync (0 = active-low)
- clk  in  1  pixel clock, 65 MHz, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- hcount  out  11  current pixel column, 0..H_TOTAL-1
- vcount  out  11  current line, 0..V_TOTAL-1
- hblnk  out  1  high when hcount >= H_ACTIVE
- vblnk  out  1  high when vcount >= V_ACTIVE
- hsync  out  1  equals HS_POL while hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
- vsync  out  1  equals VS_POL while vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- frame_start  out  1  one-cycle strobe, high when hcount==0 and vcount==0

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344 and V_TOTAL = 806 with defaults. Both must fit 11 bits; this is checked at elaboration.
- Horizontal counter: increments by 1 every cycle and wraps from H_TOTAL-1 to 0.
- Vertical counter: increments only on the cycle where hcount wraps. It wraps from V_TOTAL-1 to 0 on that same cycle.
- All outputs are registers. Next-state decode is computed from the next counter values, so blnk, sync and frame_start in a given cycle describe the hcount/vcount presented in that same cycle. No output is ever a combinational decode of the registered counters.
- Default sync windows:
  - hsync active for hcount 1048..1183.
  - vsync active for vcount 771..776, over full lines.
  - vsync changes state only at hcount==0.
- No enable and no handshake: the generator runs whenever not in reset.

## Timing
- Values held while rst is asserted:
  - hcount=0, vcount=0
  - hblnk=0, vblnk=0
  - hsync=~HS_POL, vsync=~VS_POL
  - frame_start=0
- Reset release:
  - First rising edge after rst deasserts: hcount=1, vcount=0.
  - Pixel (0,0) of frame 0 is the reset state itself, so no frame_start is emitted for it.
  - The first frame_start comes H_TOTAL*V_TOTAL cycles after release. That is 1,083,264 cycles, about 16.67 ms, with defaults.
- Reset mid-frame: all outputs go to reset values immediately (asynchronous). The following frame has full length; no partial-line artefacts.
- Line period is H_TOTAL cycles; frame period is H_TOTAL*V_TOTAL cycles, exactly.
- hblnk rises at hcount==H_ACTIVE and falls at hcount==0. vblnk rises at vcount==V_ACTIVE with hcount==0.
- Latency of every output relative to the counters: 0 cycles (co-registered).

## Test plan
- **Reset state:** hold rst high for 5 cycles with clk running.
  - Required: hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=1, vsync=1, frame_start=0 throughout.
  - On the first edge after release: hcount=1.
- **Line timing:** run 2 lines.
  - hblnk goes 0→1 exactly when hcount=1024.
  - hsync goes low at hcount=1048 and returns high at hcount=1184.
  - hcount goes 1343→0 and vcount 0→1 on the same edge.
- **Frame wrap:** run to vcount=805, hcount=1343.
  - Next edge gives hcount=0, vcount=0, frame_start=1 for exactly one cycle, vblnk=0.
  - Measured frame period is 1,083,264 cycles.
- **Vertical sync:**
  - vsync is low exactly for vcount 771..776, i.e. 6×1344 = 8064 cycles.
  - Edges occur only at hcount=0.
  - vblnk is high for vcount 768..805.
- **Mid-frame reset:** pulse rst asynchronously (not edge-aligned) at vcount=400, hcount=700.
  - Outputs reach reset values without waiting for a clock edge.
  - After release, the next frame_start arrives after 1,083,264 cycles.
- **Parameter override:** H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33, HS_POL=VS_POL=0.
  - Line period is 800 cycles; frame period is 420,000 cycles.
  - hsync is active for hcount 656..751.
